// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl
// Capture sequencer for the PDM microphone chain. It owns the PDM clock rate
// select and the accumulator sync strobe. After each (re)sync it throws away
// a programmable number of settling words, then buffers accumulator words in
// a small first-word-fall-through FIFO that is drained with valid/ready.

module pdm_capture_ctrl #(
    parameter int ACCUM_BITS   = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int WARMUP_WORDS = 16,
    parameter int LVL_BITS     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  mode_req,
    output logic                  mode,
    output logic                  accum_sync,
    input  logic                  accum_clk,
    input  logic [ACCUM_BITS-1:0] accum_data,
    output logic [ACCUM_BITS-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LVL_BITS-1:0]   fifo_level,
    output logic                  overflow,
    output logic                  busy,
    output logic [1:0]            state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = (WARMUP_WORDS > 0) ? $clog2(WARMUP_WORDS + 1) : 1;

    localparam logic [CNT_W-1:0]    WARM_TARGET = CNT_W'(WARMUP_WORDS);
    localparam logic [CNT_W-1:0]    WARM_ONE    = CNT_W'(1);
    localparam logic [LVL_BITS-1:0] LVL_FULL    = LVL_BITS'(FIFO_DEPTH);
    localparam logic [LVL_BITS-1:0] LVL_ONE     = LVL_BITS'(1);
    localparam logic [PTR_W-1:0]    PTR_ONE     = PTR_W'(1);
    localparam logic [PTR_W-1:0]    PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t state_q;
    state_t state_next;

    logic                  mode_q;
    logic                  sync_q;
    logic [CNT_W-1:0]      warm_cnt;
    logic                  overflow_q;

    logic                  mode_load;
    logic                  warm_clear;
    logic                  warm_inc;
    logic                  push_req;
    logic                  ovf_clear;
    logic                  rate_change;

    logic [ACCUM_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_BITS-1:0]   level_q;

    logic                  fifo_full;
    logic                  pop;
    logic                  push_ok;
    logic                  ovf_set;

    assign rate_change = (mode_req != mode_q);

    // Next-state decode and the per-cycle control strobes, in priority order
    // enable drop > rate change > accumulator word.
    always_comb begin
        state_next = state_q;
        mode_load  = 1'b0;
        warm_clear = 1'b0;
        warm_inc   = 1'b0;
        push_req   = 1'b0;
        ovf_clear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mode_load = 1'b1;
                if (enable) begin
                    state_next = ST_SYNC;
                    ovf_clear  = 1'b1;
                end
            end
            ST_SYNC: begin
                warm_clear = 1'b1;
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (WARMUP_WORDS == 0) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (rate_change) begin
                    mode_load  = 1'b1;
                    state_next = ST_SYNC;
                end else if (accum_clk) begin
                    warm_inc = 1'b1;
                    if ((warm_cnt + WARM_ONE) == WARM_TARGET) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (rate_change) begin
                    mode_load  = 1'b1;
                    state_next = ST_SYNC;
                end else begin
                    push_req = accum_clk;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; the sync strobe is registered alongside so it is high
    // for exactly the cycle spent in SYNC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            sync_q  <= (state_next == ST_SYNC);
        end
    end

    // Rate select follows the request while idle and latches on a rate change.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (mode_load) begin
            mode_q <= mode_req;
        end
    end

    // Settling-word counter, cleared in SYNC and advanced per discarded word.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= '0;
        end else if (warm_clear) begin
            warm_cnt <= '0;
        end else if (warm_inc) begin
            warm_cnt <= warm_cnt + WARM_ONE;
        end
    end

    // FIFO handshake decode: a full FIFO still accepts a word if the head
    // leaves in the same cycle.
    assign fifo_full = (level_q == LVL_FULL);
    assign pop       = (level_q != '0) && out_ready;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign ovf_set   = push_req && fifo_full && !pop;

    // FIFO storage; entries are cleared on reset so the head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= accum_data;
        end
    end

    // Read/write pointers wrapping modulo the depth, plus occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky drop flag, cleared only by reset or a fresh start from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (ovf_clear) begin
            overflow_q <= 1'b0;
        end else if (ovf_set) begin
            overflow_q <= 1'b1;
        end
    end

    assign mode       = mode_q;
    assign accum_sync = sync_q;
    assign out_data   = mem[rd_ptr];
    assign out_valid  = (level_q != '0);
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != ST_IDLE);
    assign state      = state_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Self-checking bench for pdm_capture_ctrl (4-bit words, depth 8, 4 warmup
// words). Words expected to be stored are queued as they are issued; a
// monitor compares every accepted head word against the queue front.

module tb_pdm_capture_ctrl;

    localparam int AB = 4;
    localparam int DEPTH = 8;
    localparam int WARM = 4;
    localparam int LB = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          mode_req;
    logic          mode;
    logic          accum_sync;
    logic          accum_clk;
    logic [AB-1:0] accum_data;
    logic [AB-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LB-1:0] fifo_level;
    logic          overflow;
    logic          busy;
    logic [1:0]    state;

    int checks = 0;
    int failures = 0;
    int expq[$];

    pdm_capture_ctrl #(
        .ACCUM_BITS  (AB),
        .FIFO_DEPTH  (DEPTH),
        .WARMUP_WORDS(WARM),
        .LVL_BITS    (LB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode_req   (mode_req),
        .mode       (mode),
        .accum_sync (accum_sync),
        .accum_clk  (accum_clk),
        .accum_data (accum_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .busy       (busy),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One cycle with an accumulator word; store=1 means it must reach the FIFO.
    task automatic applyStimulus(input int data, input bit store);
        accum_clk  = 1'b1;
        accum_data = AB'(data);
        step(1);
        accum_clk  = 1'b0;
        if (store) expq.push_back(data);
    endtask

    // Head-word monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_pop", int'(out_data), -1);
                end else begin
                    checkOutput("pop_data", int'(out_data), expq.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; mode_req = 1'b0;
        accum_clk = 1'b0; accum_data = '0; out_ready = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset values
        checkOutput("rst_state", int'(state), 0);
        checkOutput("rst_mode", int'(mode), 0);
        checkOutput("rst_sync", int'(accum_sync), 0);
        checkOutput("rst_valid", int'(out_valid), 0);
        checkOutput("rst_data", int'(out_data), 0);
        checkOutput("rst_level", int'(fifo_level), 0);
        checkOutput("rst_ovf", int'(overflow), 0);
        checkOutput("rst_busy", int'(busy), 0);

        // 1: start, one-cycle sync, warmup discard, first captured word
        enable = 1'b1;
        step(1);
        checkOutput("t1_state_sync", int'(state), 1);
        checkOutput("t1_sync_hi", int'(accum_sync), 1);
        checkOutput("t1_busy", int'(busy), 1);
        step(1);
        checkOutput("t1_state_warm", int'(state), 2);
        checkOutput("t1_sync_lo", int'(accum_sync), 0);
        for (int i = 1; i <= 3; i++) applyStimulus(i, 1'b0);
        checkOutput("t1_still_warm", int'(state), 2);
        applyStimulus(4, 1'b0);
        checkOutput("t1_state_run", int'(state), 3);
        checkOutput("t1_no_capture", int'(fifo_level), 0);
        applyStimulus(4'hA, 1'b1);
        checkOutput("t1_valid", int'(out_valid), 1);
        checkOutput("t1_head", int'(out_data), 10);
        checkOutput("t1_level", int'(fifo_level), 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checkOutput("t1_drained", int'(fifo_level), 0);

        // 2: overfill then drain in order
        for (int i = 0; i < 9; i++) applyStimulus(i, i < 8);
        checkOutput("t2_level_full", int'(fifo_level), 8);
        checkOutput("t2_ovf", int'(overflow), 1);
        out_ready = 1'b1;
        step(8);
        out_ready = 1'b0;
        checkOutput("t2_valid_after", int'(out_valid), 0);
        checkOutput("t2_ovf_sticky", int'(overflow), 1);
        checkOutput("t2_queue_empty", expq.size(), 0);

        // 3: restart clears overflow; push+pop on a full FIFO
        enable = 1'b0;
        step(1);
        checkOutput("t3_idle", int'(state), 0);
        checkOutput("t3_ovf_kept_idle", int'(overflow), 1);
        enable = 1'b1;
        step(1);
        checkOutput("t3_ovf_clr", int'(overflow), 0);
        step(1);
        for (int i = 0; i < 4; i++) applyStimulus(4'hF, 1'b0);
        for (int i = 1; i <= 8; i++) applyStimulus(i, 1'b1);
        checkOutput("t3_full", int'(fifo_level), 8);
        out_ready = 1'b1;
        applyStimulus(9, 1'b1);
        out_ready = 1'b0;
        checkOutput("t3_level_same", int'(fifo_level), 8);
        checkOutput("t3_no_ovf", int'(overflow), 0);
        out_ready = 1'b1;
        step(5);
        out_ready = 1'b0;
        checkOutput("t3_level3", int'(fifo_level), 3);

        // 4: rate change resyncs, discards words, keeps FIFO contents
        mode_req = 1'b1;
        applyStimulus(4'hF, 1'b0);
        checkOutput("t4_mode", int'(mode), 1);
        checkOutput("t4_state_sync", int'(state), 1);
        checkOutput("t4_sync_hi", int'(accum_sync), 1);
        checkOutput("t4_fifo_kept", int'(fifo_level), 3);
        applyStimulus(4'hE, 1'b0);
        checkOutput("t4_state_warm", int'(state), 2);
        for (int i = 0; i < 3; i++) applyStimulus(4'hD, 1'b0);
        checkOutput("t4_sync_not_counted", int'(state), 2);
        applyStimulus(4'hD, 1'b0);
        checkOutput("t4_state_run", int'(state), 3);
        applyStimulus(4'hC, 1'b1);
        checkOutput("t4_level4", int'(fifo_level), 4);

        // 5: enable drop beats a word; FIFO drains in IDLE; restart clears overflow
        for (int i = 0; i < 5; i++) applyStimulus(i + 1, i < 4);
        checkOutput("t5_ovf_set", int'(overflow), 1);
        enable = 1'b0;
        applyStimulus(5, 1'b0);
        checkOutput("t5_idle", int'(state), 0);
        checkOutput("t5_busy", int'(busy), 0);
        checkOutput("t5_level", int'(fifo_level), 8);
        out_ready = 1'b1;
        step(5);
        out_ready = 1'b0;
        checkOutput("t5_drain_idle", int'(fifo_level), 3);
        enable = 1'b1;
        step(1);
        checkOutput("t5_sync", int'(state), 1);
        checkOutput("t5_ovf_clr", int'(overflow), 0);
        step(1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0);
        checkOutput("t5_run", int'(state), 3);

        // 6: reset mid-run with data and overflow pending
        for (int i = 0; i < 6; i++) applyStimulus(i + 7, i < 5);
        out_ready = 1'b1;
        step(5);
        out_ready = 1'b0;
        checkOutput("t6_pre_level", int'(fifo_level), 3);
        checkOutput("t6_pre_ovf", int'(overflow), 1);
        rst = 1'b1;
        enable = 1'b0;
        mode_req = 1'b0;
        step(1);
        rst = 1'b0;
        expq.delete();
        checkOutput("t6_state", int'(state), 0);
        checkOutput("t6_mode", int'(mode), 0);
        checkOutput("t6_sync", int'(accum_sync), 0);
        checkOutput("t6_valid", int'(out_valid), 0);
        checkOutput("t6_data", int'(out_data), 0);
        checkOutput("t6_level", int'(fifo_level), 0);
        checkOutput("t6_ovf", int'(overflow), 0);
        checkOutput("t6_busy", int'(busy), 0);
        applyStimulus(6, 1'b0);
        checkOutput("t6_idle_ignore", int'(fifo_level), 0);
        checkOutput("t6_idle_state", int'(state), 0);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pdm_capture_ctrl.md
Name: pdm_capture_ctrl

Overview:
Sequencer for the PDM microphone capture chain. It owns the clock-generator rate select (mode) and the sync strobe to the accumulator/decimator. After every start or rate change it discards a programmable number of settling words. It then buffers valid accumulator words in a small FWFT FIFO, which downstream logic drains with a valid/ready handshake.

Parameters:
ACCUM_BITS, 4, width of accumulator words received and emitted
FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2
WARMUP_WORDS, 16, accumulator words discarded after each (re)sync; 0 means no discard
LVL_BITS, $clog2(FIFO_DEPTH)+1, width of fifo_level

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
enable  in  1  level; 1 = capture requested
mode_req  in  1  requested PDM clock rate select
mode  out  1  registered rate select driven to the PDM clock generator
accum_sync  out  1  one-cycle strobe to the accumulator sync input
accum_clk  in  1  one-cycle word strobe from the accumulator
accum_data  in  ACCUM_BITS  accumulator word; valid when accum_clk=1
out_data  out  ACCUM_BITS  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts the head word
fifo_level  out  LVL_BITS  current FIFO occupancy
overflow  out  1  sticky; a RUN word was dropped because the FIFO was full
busy  out  1  state != IDLE
state  out  2  IDLE=0, SYNC=1, WARMUP=2, RUN=3

Behaviour:
- Reset (rst=1 at an edge) takes priority over everything. After reset: state=IDLE, mode=0, accum_sync=0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, overflow=0, busy=0, warmup counter=0.
- IDLE: mode <= mode_req every cycle. If enable=1: go to SYNC and clear overflow.
- SYNC: lasts exactly one cycle. accum_sync=1 only while state==SYNC (registered, decoded from state). Warmup counter cleared. Next state: WARMUP, or RUN if WARMUP_WORDS=0.
- WARMUP: each accum_clk increments the counter and discards the word. The accum_clk that brings the count to WARMUP_WORDS is also discarded, and state goes to RUN on that edge. accum_clk during SYNC is ignored and not counted.
- RUN: accum_clk=1 pushes accum_data. If the FIFO is full and no pop happens that cycle, the word is dropped and overflow is set.
- Enable drop: enable=0 in SYNC, WARMUP or RUN moves to IDLE on the next edge. An accum_clk in that same cycle is not pushed. FIFO contents are retained and stay drainable.
- Rate change: in WARMUP or RUN, if mode_req != mode while enable=1, then on that edge mode <= mode_req and state goes to SYNC. Any accum_clk that cycle is discarded. The FIFO is not flushed. Enable=0 has priority over a rate change.
- Priority order: rst > enable=0 > mode change > accum_clk.
- FIFO is first-word-fall-through:
  - out_valid = (fifo_level != 0); out_data = head entry.
  - Pop when out_valid && out_ready.
  - A word pushed at edge N is visible at the head after edge N (one cycle latency) if the FIFO was empty.
  - Push and pop in the same cycle: both happen and the level is unchanged. This includes full (no overflow) and empty (no push+pop possible, since out_valid=0, so the level goes to 1).
  - Read and write pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
- Popping is permitted in every state, including IDLE.
- overflow is cleared only by rst or by the IDLE->SYNC transition.

Test Plan:
1. WARMUP_WORDS=4, depth 8, mode_req=0. Reset, enable=1 -> accum_sync high exactly one cycle (state 1). accum_clk words 1,2,3,4 -> discarded, state=3 after the 4th. Word 0xA -> out_valid=1, out_data=0xA, fifo_level=1 one cycle after the strobe.
2. RUN with out_ready=0, push 9 words 0..8 -> fifo_level=8, overflow=1, word 8 lost. Then out_ready=1 -> words 0..7 drain in order and out_valid=0 afterwards; overflow stays 1.
3. FIFO full, accum_clk=1 and out_ready=1 in the same cycle -> fifo_level stays 8, overflow stays 0, the new word becomes the tail.
4. RUN, toggle mode_req 0->1 -> mode=1 next edge, state=SYNC, accum_sync pulse. The next 4 words are discarded, then capture resumes. The FIFO keeps its prior words.
5. RUN, enable falls in the same cycle as accum_clk (data 0x5) -> 0x5 not stored, state=IDLE, busy=0, FIFO still drains. Re-enable -> overflow cleared on entry to SYNC.
6. RUN with fifo_level=3 and overflow=1, assert rst for 1 cycle -> all outputs at reset values; the next accum_clk is ignored while IDLE.
